// File: rtl/mem_reg_pkg.sv
// Shared types and default sizing for the register bank and its address decoders.
// Holds the clear/ready sweep state encoding used by mem_reg_bank.
package mem_reg_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_BASE_ADDR = 32;
  localparam int DEF_NRD       = 3;

endpackage

// File: rtl/mem_reg_addr_dec.sv
// Address decoder: entry index = addr - BASE_ADDR (ADDR_W-bit wrap) plus range check.
// Purely combinational, no handshake.
module mem_reg_addr_dec #(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 32,
  parameter int BASE_ADDR = 32,
  parameter int IDX_W     = 5
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_in_range,
  output logic [IDX_W-1:0]  o_idx
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [ADDR_W-1:0] w_off;

  assign w_off      = i_addr - BASE;
  // Both terms needed: the subtraction wraps for addresses below the base.
  assign o_in_range = (i_addr >= BASE) && (33'(w_off) < 33'(DEPTH));
  assign o_idx      = w_off[IDX_W-1:0];

endmodule

// File: rtl/mem_reg_bank.sv
// Multi-read-port register bank with range checking and a zero-fill sweep after reset/clear.
// Reads return 1 cycle after rd_en; no backpressure, accesses are dropped while busy.
module mem_reg_bank
  import mem_reg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int NRD       = DEF_NRD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [NRD-1:0]        rd_err,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_err,
  input  logic                  clr_req,
  output logic                  busy
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_sweep;
  logic               w_busy;
  logic               w_ready;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [NRD*DATA_W-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic [NRD-1:0]        r_rd_err;
  logic                  r_wr_err;

  logic                  w_wr_ok;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [NRD-1:0]        w_rd_ok;
  logic [IDX_W-1:0]      w_rd_idx [NRD];

  mem_reg_addr_dec #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_wr_dec (
    .i_addr(wr_addr), .o_in_range(w_wr_ok), .o_idx(w_wr_idx)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd_dec
    mem_reg_addr_dec #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_rd_dec (
      .i_addr(rd_addr[k*ADDR_W +: ADDR_W]), .o_in_range(w_rd_ok[k]), .o_idx(w_rd_idx[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR && r_sweep != LAST_IDX)
        r_sweep <= r_sweep + 1'b1;
      else
        r_sweep <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_sweep == LAST_IDX) w_state_nxt = READY;
      READY:   if (clr_req) w_state_nxt = CLEAR;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    w_busy  = (r_state == CLEAR);
    w_ready = (r_state == READY);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_busy)
        r_mem[r_sweep] <= '0;
      else if (wr_en && w_wr_ok)
        r_mem[w_wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_ready && rd_en;
      r_wr_err   <= w_ready && wr_en && !w_wr_ok;
      if (w_ready && rd_en) begin
        for (int k = 0; k < NRD; k++) begin
          r_rd_err[k] <= !w_rd_ok[k];
          // Same-edge write to the same entry is forwarded so readers see the new value.
          if (!w_rd_ok[k])
            r_rd_data[k*DATA_W +: DATA_W] <= '0;
          else if (wr_en && w_wr_ok && (w_wr_idx == w_rd_idx[k]))
            r_rd_data[k*DATA_W +: DATA_W] <= wr_data;
          else
            r_rd_data[k*DATA_W +: DATA_W] <= r_mem[w_rd_idx[k]];
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign wr_err   = r_wr_err;
  assign busy     = w_busy;

endmodule

// File: doc/mem_reg_bank.md
MEM_REG_BANK -- requirements
Module: mem_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter DEPTH, default 32, number of storage entries.
REQ-004 SHALL have parameter BASE_ADDR, default 32, lowest valid address; valid range is BASE_ADDR..BASE_ADDR+DEPTH-1.
REQ-005 SHALL have parameter NRD, default 3, number of read ports.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 rd_en  input  1  read strobe, shared by all read ports.
REQ-009 rd_addr  input  NRD*ADDR_W  packed read addresses; port k occupies bits k*ADDR_W +: ADDR_W.
REQ-010 rd_data  output  NRD*DATA_W  packed registered read data, same packing.
REQ-011 rd_valid  output  1  rd_data updated this cycle.
REQ-012 rd_err  output  NRD  per-port out-of-range flag, qualified by rd_valid.
REQ-013 wr_en  input  1  write strobe.
REQ-014 wr_addr  input  ADDR_W  write address.
REQ-015 wr_data  input  DATA_W  write data.
REQ-016 wr_err  output  1  one-cycle pulse: rejected out-of-range write.
REQ-017 clr_req  input  1  request a full clear sweep.
REQ-018 busy  output  1  clear sweep in progress; all accesses ignored.

Function
REQ-019 SHALL implement FSM states CLEAR and READY; reset enters CLEAR with sweep index 0.
REQ-020 In CLEAR, SHALL write 0 to entry at sweep index each cycle and increment it; after entry DEPTH-1 is written, the next state SHALL be READY (sweep lasts exactly DEPTH cycles).
REQ-021 busy SHALL be 1 exactly while state is CLEAR.
REQ-022 In READY, clr_req=1 SHALL transition to CLEAR with index 0 on the next edge; clr_req in CLEAR SHALL be ignored.
REQ-023 In CLEAR, rd_en, wr_en and clr_req SHALL have no effect; rd_valid and wr_err SHALL remain 0.
REQ-024 Entry index SHALL be addr - BASE_ADDR in ADDR_W-bit unsigned arithmetic; an address is in range iff addr >= BASE_ADDR and addr - BASE_ADDR < DEPTH.
REQ-025 Read latency SHALL be 1 cycle: rd_en=1 in READY at edge N yields rd_valid=1 and rd_data/rd_err during cycle N+1.
REQ-026 rd_valid SHALL be 0 in any cycle not following an accepted read.
REQ-027 When rd_en=0, rd_data and rd_err SHALL hold their previous values.
REQ-028 Out-of-range read port SHALL return rd_data 0 for that port and rd_err bit 1; in-range port SHALL have rd_err bit 0.
REQ-029 Write with wr_en=1 in READY and in-range wr_addr SHALL update the entry at that edge.
REQ-030 Out-of-range write SHALL leave storage unchanged and pulse wr_err for the following cycle.
REQ-031 Simultaneous read and write of the same in-range address SHALL return the new wr_data (write-through bypass), independently per port.
REQ-032 Multiple read ports addressing the same entry SHALL all return identical data.

Reset
REQ-033 reset=1 at an edge SHALL set rd_data=0, rd_valid=0, rd_err=0, wr_err=0, state=CLEAR, index=0, busy=1 during the following cycle.
REQ-034 reset asserted mid-sweep SHALL restart the sweep from index 0; a full DEPTH-cycle sweep follows reset deassertion.
REQ-035 Reset SHALL have priority over clr_req, rd_en and wr_en.

Structure
REQ-036 Shared package mem_reg_pkg SHALL hold the FSM state type (CLEAR, READY) and default parameter constants.
REQ-037 Range check and index calculation SHALL be in sub-module mem_reg_addr_dec, instantiated once per read port and once for the write port.

Verification
REQ-038 Reset 1 cycle, then idle -> busy=1 for exactly 32 cycles, then 0; read of addresses 32..63 returns 0, rd_err=0.
REQ-039 Write 0x1234 to 48 and 0x00AB to 52; next cycle read ports (48,52,48) -> rd_data (0x1234,0x00AB,0x1234), rd_valid=1 one cycle later.
REQ-040 Same cycle write 0xBEEF to 40 and read port0 at 40 -> port0 returns 0xBEEF next cycle.
REQ-041 Write to 31 and 64 -> wr_err pulses each time, storage unchanged; read port1 at 64 -> rd_data port1 0, rd_err=3'b010.
REQ-042 clr_req after writes -> busy 32 cycles, writes during sweep ignored, all entries read 0 afterwards.
REQ-043 reset asserted at sweep cycle 10 -> sweep restarts, busy stays 1 for 32 cycles after reset release.
